// File: rtl/clk_div_pkg.sv
// Shared constants and types for the clk_div_bank divider bank.
package clk_div_pkg;

   localparam int DIV_DISABLED = 0;
   localparam int DEF_DIV_W    = 8;

   typedef enum logic [1:0] {
      EVT_NONE,
      EVT_RISE,
      EVT_FALL
   } div_evt_e;

endpackage

// File: rtl/clk_div_if.sv
// Config port of clk_div_bank. The optional cfg_phase field exists only when
// CLK_DIV_PHASE_EN is defined.
interface clk_div_if #(
   parameter int DIV_W = clk_div_pkg::DEF_DIV_W,
   parameter int CH_W  = 2
);
   // A transfer happens on a clk edge where cfg_valid && cfg_ready. The requester
   // may hold cfg_valid but must keep cfg_ch/cfg_div stable while stalled.
   logic             cfg_valid;
   logic             cfg_ready;
   logic [CH_W-1:0]  cfg_ch;
   logic [DIV_W-1:0] cfg_div;
`ifdef CLK_DIV_PHASE_EN
   logic [DIV_W-1:0] cfg_phase;

   modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
`else
   modport master (output cfg_valid, cfg_ch, cfg_div, input cfg_ready);
   modport slave  (input cfg_valid, cfg_ch, cfg_div, output cfg_ready);
`endif
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: counter, active/shadow/pending divisor and registered
// clk_out with rise/fall strobes. Phase load enabled by CLK_DIV_PHASE_EN.
module clk_div_ch
   import clk_div_pkg::*;
#(
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sync,
   input  logic             cfg_we,
   input  logic [DIV_W-1:0] cfg_div,
`ifdef CLK_DIV_PHASE_EN
   input  logic [DIV_W-1:0] cfg_phase,
`endif
   output logic             pending,
   output logic             clk_out,
   output logic             rise,
   output logic             fall
);

   logic [DIV_W-1:0] active, shadow, cnt;
   logic [DIV_W-1:0] active_n, shadow_n, cnt_n;
   logic             pending_n, clk_n, apply, load;
   div_evt_e         evt;
`ifdef CLK_DIV_PHASE_EN
   logic [DIV_W-1:0] phase, phase_n;
`endif

   always_comb begin
      active_n  = active;
      shadow_n  = shadow;
      pending_n = pending;
      cnt_n     = cnt;
      clk_n     = clk_out;
      evt       = EVT_NONE;
      apply     = 1'b0;
      load      = 1'b0;
`ifdef CLK_DIV_PHASE_EN
      phase_n   = cfg_we ? cfg_phase : phase;
`endif
      if (cfg_we) begin
         shadow_n  = cfg_div;
         pending_n = 1'b1;
      end
      // A transfer in the sync cycle applies at that sync; elsewhere it waits
      // for the next boundary because only the registered pending is consulted.
      if (sync) begin
         load  = 1'b1;
         clk_n = 1'b0;
         if (clk_out) evt = EVT_FALL;
         apply = pending_n;
      end else if (active == DIV_W'(DIV_DISABLED)) begin
         cnt_n = '0;
         clk_n = 1'b0;
         if (clk_out) evt = EVT_FALL;
         apply = pending;
      end else if (cnt == active - DIV_W'(1)) begin
         cnt_n = '0;
         clk_n = !clk_out;
         evt   = clk_out ? EVT_FALL : EVT_RISE;
         apply = clk_out && pending;
      end else begin
         cnt_n = cnt + DIV_W'(1);
      end
      if (apply) begin
         active_n  = shadow_n;
         pending_n = 1'b0;
         load      = 1'b1;
      end
      if (load) begin
`ifdef CLK_DIV_PHASE_EN
         cnt_n = (phase_n >= active_n) ? '0 : phase_n;
`else
         cnt_n = '0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         active  <= DIV_W'(DEFAULT_DIV);
         shadow  <= DIV_W'(DEFAULT_DIV);
         pending <= 1'b0;
         cnt     <= '0;
         clk_out <= 1'b0;
         rise    <= 1'b0;
         fall    <= 1'b0;
`ifdef CLK_DIV_PHASE_EN
         phase   <= '0;
`endif
      end else begin
         active  <= active_n;
         shadow  <= shadow_n;
         pending <= pending_n;
         cnt     <= cnt_n;
         clk_out <= clk_n;
         rise    <= (evt == EVT_RISE);
         fall    <= (evt == EVT_FALL);
`ifdef CLK_DIV_PHASE_EN
         phase   <= phase_n;
`endif
      end
   end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of N_CH programmable clock dividers with a shared realigning sync.
// Optional per-channel start phase enabled by CLK_DIV_PHASE_EN.
module clk_div_bank
   import clk_div_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int DIV_W       = DEF_DIV_W,
   parameter int DEFAULT_DIV = 5,
   parameter int CH_W        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            sync,
   clk_div_if.slave        cfg,
   output logic [N_CH-1:0] clk_out,
   output logic [N_CH-1:0] rise,
   output logic [N_CH-1:0] fall
);

   logic [N_CH-1:0] pending, sel, we;
   logic            ready_c;

   // Channel numbers with no channel behind them stay ready and select nothing.
   always_comb begin
      ready_c = 1'b1;
      sel     = '0;
      for (int i = 0; i < N_CH; i++) begin
         if (cfg.cfg_ch == CH_W'(i)) begin
            sel[i]  = 1'b1;
            ready_c = !pending[i];
         end
      end
   end

   assign cfg.cfg_ready = ready_c;
   assign we = sel & {N_CH{cfg.cfg_valid && ready_c}};

   for (genvar g = 0; g < N_CH; g++) begin : g_ch
      clk_div_ch #(
         .DIV_W       (DIV_W),
         .DEFAULT_DIV (DEFAULT_DIV)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .sync      (sync),
         .cfg_we    (we[g]),
         .cfg_div   (cfg.cfg_div),
`ifdef CLK_DIV_PHASE_EN
         .cfg_phase (cfg.cfg_phase),
`endif
         .pending   (pending[g]),
         .clk_out   (clk_out[g]),
         .rise      (rise[g]),
         .fall      (fall[g])
      );
   end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank: per-edge expectation tables plus
// hand-written config/sync/reset sequences.
module tb_clk_div_bank;

   localparam int N_CH        = 4;
   localparam int DIV_W       = 8;
   localparam int DEFAULT_DIV = 5;
   localparam int CH_W        = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic            sync;
   logic [N_CH-1:0] clk_out, rise, fall;

   clk_div_if #(.DIV_W(DIV_W), .CH_W(CH_W)) cfg_if ();

   clk_div_bank #(
      .N_CH        (N_CH),
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV),
      .CH_W        (CH_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .sync    (sync),
      .cfg     (cfg_if.slave),
      .clk_out (clk_out),
      .rise    (rise),
      .fall    (fall)
   );

   always #5 clk = ~clk;

   typedef struct {
      int              edge_n;
      logic [N_CH-1:0] exp_clk;
      logic [N_CH-1:0] exp_rise;
      logic [N_CH-1:0] exp_fall;
   } vec_t;

   vec_t vq[$];
   int   edge_n;
   int   checks;
   int   errors;

   task automatic step();
      @(posedge clk);
      #1;
      edge_n++;
   endtask

   task automatic step_to(input int e);
      while (edge_n < e) step();
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add_vec(input int e, input logic [N_CH-1:0] c, input logic [N_CH-1:0] r,
                          input logic [N_CH-1:0] f);
      vec_t v;
      v.edge_n   = e;
      v.exp_clk  = c;
      v.exp_rise = r;
      v.exp_fall = f;
      vq.push_back(v);
   endtask

   task automatic run_vecs(input string tag);
      vec_t v;
      while (vq.size() > 0) begin
         v = vq.pop_front();
         step_to(v.edge_n);
         check($sformatf("%s@%0d clk_out", tag, v.edge_n), 32'(clk_out), 32'(v.exp_clk));
         check($sformatf("%s@%0d rise", tag, v.edge_n), 32'(rise), 32'(v.exp_rise));
         check($sformatf("%s@%0d fall", tag, v.edge_n), 32'(fall), 32'(v.exp_fall));
      end
   endtask

   // Only called while cfg_valid is low so that moving cfg_ch cannot transfer.
   task automatic check_ready(input string name, input int ch, input logic exp);
      cfg_if.cfg_ch = CH_W'(ch);
      #1;
      check(name, 32'(cfg_if.cfg_ready), 32'(exp));
   endtask

   task automatic drive_cfg(input int ch, input int div, input int ph);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_ch    = CH_W'(ch);
      cfg_if.cfg_div   = DIV_W'(div);
`ifdef CLK_DIV_PHASE_EN
      cfg_if.cfg_phase = DIV_W'(ph);
`else
      if (ph != 0) $display("note: phase %0d ignored in this build", ph);
`endif
   endtask

   task automatic write_cycle(input int ch, input int div, input int ph);
      drive_cfg(ch, div, ph);
      step();
      cfg_if.cfg_valid = 1'b0;
   endtask

   // Default divisor 5 on every channel: rise on edge 5, fall on 10, period 10.
   task automatic load_reset_table();
      add_vec(3,  4'b0000, 4'b0000, 4'b0000);
      add_vec(4,  4'b0000, 4'b0000, 4'b0000);
      add_vec(5,  4'b1111, 4'b1111, 4'b0000);
      add_vec(6,  4'b1111, 4'b0000, 4'b0000);
      add_vec(9,  4'b1111, 4'b0000, 4'b0000);
      add_vec(10, 4'b0000, 4'b0000, 4'b1111);
      add_vec(11, 4'b0000, 4'b0000, 4'b0000);
      add_vec(15, 4'b1111, 4'b1111, 4'b0000);
      add_vec(20, 4'b0000, 4'b0000, 4'b1111);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      edge_n = 0;
      rst = 1'b1;
      sync = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_ch    = '0;
      cfg_if.cfg_div   = '0;
`ifdef CLK_DIV_PHASE_EN
      cfg_if.cfg_phase = '0;
`endif
      repeat (3) step();
      check("reset clk_out", 32'(clk_out), 32'h0);
      check("reset rise", 32'(rise), 32'h0);
      check("reset fall", 32'(fall), 32'h0);
      for (int c = 0; c < N_CH; c++) check_ready($sformatf("reset ready ch%0d", c), c, 1'b1);

      rst = 1'b0;
      edge_n = 0;
      load_reset_table();
      run_vecs("rst");

      // ch1 <= 3 written in its high phase; stalls until the 1->0 wrap at edge 30.
      step_to(27);
      write_cycle(1, 3, 0);
      check_ready("ch1 stalled@28", 1, 1'b0);
      step_to(29);
      check_ready("ch1 stalled@29", 1, 1'b0);
      step_to(30);
      check_ready("ch1 applied@30", 1, 1'b1);
      add_vec(30, 4'b0000, 4'b0000, 4'b1111);
      add_vec(33, 4'b0010, 4'b0010, 4'b0000);
      add_vec(35, 4'b1111, 4'b1101, 4'b0000);
      add_vec(36, 4'b1101, 4'b0000, 4'b0010);
      add_vec(39, 4'b1111, 4'b0010, 4'b0000);
      add_vec(40, 4'b0010, 4'b0000, 4'b1101);
      run_vecs("div3");

      // ch2 disabled at its next period end, then re-enabled at 2 via rule b.
      step_to(46);
      write_cycle(2, 0, 0);
      check_ready("ch2 dis stalled", 2, 1'b0);
      add_vec(50, 4'b0000, 4'b0000, 4'b1101);
      run_vecs("dis");
      write_cycle(2, 2, 0);
      add_vec(51, 4'b0010, 4'b0010, 4'b0000);
      run_vecs("reen");
      check_ready("ch2 reen pending", 2, 1'b0);
      step_to(52);
      check_ready("ch2 reen applied", 2, 1'b1);
      add_vec(52, 4'b0010, 4'b0000, 4'b0000);
      add_vec(53, 4'b0010, 4'b0000, 4'b0000);
      add_vec(54, 4'b0100, 4'b0100, 4'b0010);
      add_vec(55, 4'b1101, 4'b1001, 4'b0000);
      add_vec(56, 4'b1001, 4'b0000, 4'b0100);
      add_vec(57, 4'b1011, 4'b0010, 4'b0000);
      add_vec(58, 4'b1111, 4'b0100, 4'b0000);
      add_vec(60, 4'b0000, 4'b0000, 4'b1111);
      run_vecs("div2");

      // ch0 pending 7, ch3 written 2 in the sync cycle; ch2 is high at sync.
      write_cycle(0, 7, 0);
      add_vec(62, 4'b0100, 4'b0100, 4'b0000);
      run_vecs("presync");
      sync = 1'b1;
      drive_cfg(3, 2, 0);
      step();
      sync = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      check_ready("ch0 applied by sync", 0, 1'b1);
      check_ready("ch3 applied by sync", 3, 1'b1);
      add_vec(63, 4'b0000, 4'b0000, 4'b0100);
      add_vec(64, 4'b0000, 4'b0000, 4'b0000);
      add_vec(65, 4'b1100, 4'b1100, 4'b0000);
      add_vec(66, 4'b1110, 4'b0010, 4'b0000);
      add_vec(67, 4'b0010, 4'b0000, 4'b1100);
      add_vec(69, 4'b1100, 4'b1100, 4'b0010);
      add_vec(70, 4'b1101, 4'b0001, 4'b0000);
      run_vecs("sync");

      // Reset with ch1 pending 9 discards the pending value.
      write_cycle(1, 9, 0);
      check_ready("ch1 pending before rst", 1, 1'b0);
      rst = 1'b1;
      step();
      step();
      check("rst2 clk_out", 32'(clk_out), 32'h0);
      check("rst2 rise", 32'(rise), 32'h0);
      check("rst2 fall", 32'(fall), 32'h0);
      check_ready("rst2 ch1 ready", 1, 1'b1);
      rst = 1'b0;
      edge_n = 0;
      load_reset_table();
      run_vecs("rst2");

`ifdef CLK_DIV_PHASE_EN
      // ch0 phase 1 leads ch1 by one cycle; ch2 phase 6 >= 4 loads 0.
      write_cycle(0, 4, 1);
      write_cycle(1, 4, 0);
      sync = 1'b1;
      drive_cfg(2, 4, 6);
      step();
      sync = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      add_vec(23, 4'b0000, 4'b0000, 4'b0000);
      add_vec(25, 4'b0000, 4'b0000, 4'b0000);
      add_vec(26, 4'b0001, 4'b0001, 4'b0000);
      add_vec(27, 4'b0111, 4'b0110, 4'b0000);
      add_vec(28, 4'b1111, 4'b1000, 4'b0000);
      run_vecs("phase");
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Bank of `N_CH` independent clock dividers for the ADC testbench and sample-timing path. Each channel's half-period divisor is programmable at run time through a valid/ready config port. Divisor changes are applied glitch-free at full-period boundaries. A shared `sync` pulse phase-aligns all channels. Each channel drives a divided clock plus single-cycle rise/fall strobes, for use as clock enables in the `clk` domain.

## Interface
- `N_CH`, 4: number of divider channels (≥1).
- `DIV_W`, 8: divisor width; half-period range 1..2^DIV_W−1.
- `DEFAULT_DIV`, 5: half-period loaded into every channel at reset (0 = disabled).
- `CH_W`, `$clog2(N_CH)` (min 1): channel-select width.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sync`  in  1  one-cycle pulse; realigns all channels.
- `cfg_valid`  in  1  config request.
- `cfg_ready`  out  1  config can be accepted for `cfg_ch`.
- `cfg_ch`  in  CH_W  target channel; values ≥`N_CH` are accepted and discarded.
- `cfg_div`  in  DIV_W  new half-period; 0 disables the channel.
- `clk_out`  out  N_CH  divided clocks, registered.
- `rise`  out  N_CH  one-cycle strobe, coincident with the `clk_out` 0→1 register update.
- `fall`  out  N_CH  one-cycle strobe, coincident with the `clk_out` 1→0 register update.

## Operation
- Per-channel state: `active` divisor, `shadow` divisor, `pending` flag, counter (DIV_W bits), `clk_out`.
- Counting, with H = `active` ≠ 0:
  - Counter runs 0..H−1.
  - At H−1 it wraps to 0, toggles `clk_out`, and asserts `rise` or `fall` per the new value.
  - Output period is 2H cycles, 50% duty.
- `active` = 0 (disabled): counter held at 0, `clk_out` = 0, no strobes. If `clk_out` was 1 when the channel became disabled, it drops to 0 with one `fall` strobe.
- Config handshake:
  - Transfer when `cfg_valid && cfg_ready`.
  - `cfg_ready = !pending[cfg_ch]`; it is 1 when `cfg_ch` ≥ `N_CH`.
  - On transfer: `shadow <= cfg_div`, `pending <= 1`.
  - `cfg_valid` may be held; requesters must not change `cfg_ch`/`cfg_div` while stalled.
- Apply rule: `pending` copies `shadow` into `active`, clears the counter, and clears `pending` on the first of:
  - (a) a wrap that drives `clk_out` 1→0, i.e. a full-period boundary;
  - (b) any cycle while `active` = 0;
  - (c) `sync`.
- `sync`: every channel clears its counter and `clk_out` (a `fall` strobe is emitted if `clk_out` was 1), and every pending shadow is applied.
- Simultaneous events:
  - Transfer in the same cycle as `sync`: the new value takes effect at that `sync`.
  - Transfer in the same cycle as a period-end wrap: the value becomes pending and applies at the next boundary, not the current one.
  - Two channels never interact except through `sync`.
- `rst` at any time, including mid-period or with a pending update, overrides everything. Reset values:
  - `clk_out` = 0, `rise` = 0, `fall` = 0;
  - counters = 0, `pending` = 0, `active` = `shadow` = `DEFAULT_DIV`;
  - `cfg_ready` = 1.

## Timing
- All outputs are registered; `cfg_ready` is combinational from `pending` and `cfg_ch`.
- After `rst` falls, with H = `DEFAULT_DIV`: `clk_out` rises on the H-th `clk` edge, then toggles every H edges.
- A new divisor is visible from the cycle after the boundary. The first new high phase starts H_new edges later.
- Latency from `sync` to all counters = 0 is 1 cycle. All channels with equal H stay edge-aligned thereafter.
- H = 1: `clk_out` toggles every cycle, and `rise`/`fall` alternate every cycle.

## Configuration
- `CLK_DIV_PHASE_EN` defined:
  - Adds input `cfg_phase` (DIV_W), captured with `cfg_div` into a per-channel phase register.
  - On apply and on `sync`, the counter loads `phase` instead of 0. If `phase` ≥ H, the counter loads 0.
  - The first edge after `sync` therefore comes H−phase cycles later.
  - Reset phase = 0.
- Undefined: the port and phase registers are absent, and counters always load 0.

## Structure
- Package `clk_div_pkg`:
  - `DIV_DISABLED` = 0;
  - default `DIV_W`;
  - enum `div_evt_e` {EVT_NONE, EVT_RISE, EVT_FALL}, used internally for the strobe encode.
- Sub-module `clk_div_ch`: one channel (counter, active/shadow/pending, apply rule, strobes).
- The top generates `N_CH` instances of `clk_div_ch` and holds the config demux and `cfg_ready` mux.

## Test plan
- Reset release, `DEFAULT_DIV`=5, N_CH=4 → all `clk_out` rise on edge 5, period 10, one `rise` and one `fall` strobe per period, `cfg_ready`=1.
- Write ch1 div=3 mid-high-phase → `cfg_ready[1]`=0 until the next 1→0 wrap, then period 6. Channels 0, 2, 3 are unaffected.
- Write ch2 div=0, then div=2 → ch2 goes low with one `fall` and stays low. The div=2 write applies on the next cycle (rule b), and `clk_out` rises 2 cycles later.
- Pending writes on ch0 (div=7) and ch3 (div=2) with `sync` in the same cycle → both apply immediately, all counters 0, `clk_out` all 0, first rises at +7 and +2.
- `rst` asserted with ch1 pending div=9 → after release ch1 runs at `DEFAULT_DIV`, `pending`=0.
- With `CLK_DIV_PHASE_EN`: ch0 div=4 phase=1, ch1 div=4 phase=0, then `sync` → ch0 rises 1 cycle before ch1. phase=6 on div=4 → counter loads 0.
